// File: rtl/spi_sprite_pkg.sv
// -----------------------------------------------------------------------------
// spi_sprite_pkg
// Shared definitions for the SPI sprite link (transmitter, receiver, videoGen).
//   PIX_W, SPRITE_W, SPRITE_H, IDX_W : default pixel/sprite geometry
//   spi_tx_state_t                   : transmitter FSM states
//   pixel_t                          : one {r,g,b} pixel at the default width
// -----------------------------------------------------------------------------
package spi_sprite_pkg;

   localparam int PIX_W    = 24;
   localparam int SPRITE_W = 64;
   localparam int SPRITE_H = 64;
   localparam int IDX_W    = $clog2(SPRITE_W * SPRITE_H);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} spi_tx_state_t;

   typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
// Half-period divider for the SPI transmitter. While enabled it emits a
// one-cycle tick every CLK_DIV clk cycles; the FSM advances only on ticks.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : count while high, hold at zero while low
//   clr          : restart the half-period (pixel accept)
//   tick         : last cycle of the current half-period
// -----------------------------------------------------------------------------
module spi_sck_gen
   import spi_sprite_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr || !en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_sprite_tx.sv
// -----------------------------------------------------------------------------
// spi_sprite_tx
// SPI mode-0 master that serialises 24-bit RGB sprite pixels MSB-first and
// tracks the pixel index within a SPRITE_W x SPRITE_H frame.
//   clk, reset_n         : clock, asynchronous active-low reset
//   pix_valid/pix_data   : pixel from the producer
//   pix_ready            : high in IDLE, pixel accepted on valid & ready
//   frame_sync           : restart frame (immediate in IDLE, deferred if busy)
//   sck, mosi            : SPI link; sck idles low, mosi changes with sck fall
//   busy                 : shift in progress
//   pix_idx              : index of the next pixel to be sent
//   frame_done           : one-cycle pulse when the last frame pixel completes
// Optional build macro SPI_TX_CS_EN adds cs_n, low from the accept of pixel 0
// until the frame ends (frame_done or a deferred frame_sync).
// -----------------------------------------------------------------------------
module spi_sprite_tx
   import spi_sprite_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int PIX_W    = spi_sprite_pkg::PIX_W,
   parameter int SPRITE_W = spi_sprite_pkg::SPRITE_W,
   parameter int SPRITE_H = spi_sprite_pkg::SPRITE_H,
   parameter int IDX_W    = $clog2(SPRITE_W * SPRITE_H)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pix_valid,
   input  logic [PIX_W-1:0] pix_data,
   output logic             pix_ready,
   input  logic             frame_sync,
   output logic             sck,
   output logic             mosi,
   output logic             busy,
   output logic [IDX_W-1:0] pix_idx,
   output logic             frame_done
`ifdef SPI_TX_CS_EN
   ,
   output logic             cs_n
`endif
);

   localparam int BC_W = $clog2(PIX_W);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(PIX_W - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITE_W * SPRITE_H - 1);

   spi_tx_state_t    state;
   logic [PIX_W-1:0] shreg;
   logic [BC_W-1:0]  bitcnt;
   logic             sync_pend;
   logic             tick;
   logic             accept;
   logic             frame_end;

   assign accept = pix_valid && pix_ready;

   // A frame ends on the last pixel, or early when a frame_sync arrived
   // (or is arriving) while this pixel was on the wire.
   assign frame_end = sync_pend || frame_sync || (pix_idx == LAST_IDX);

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (busy),
      .clr     (accept),
      .tick    (tick)
   );

   // NOTE: every register here, including the shift register, takes the async
   // reset so an aborted transfer leaves no stale bits; all state updates use
   // non-blocking assignments so the case arms read pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sck        <= 1'b0;
         mosi       <= 1'b0;
         pix_ready  <= 1'b0;
         busy       <= 1'b0;
         pix_idx    <= '0;
         frame_done <= 1'b0;
         shreg      <= '0;
         bitcnt     <= '0;
         sync_pend  <= 1'b0;
`ifdef SPI_TX_CS_EN
         cs_n       <= 1'b1;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               pix_ready <= 1'b1;
               if (frame_sync) pix_idx <= '0;
               if (accept) begin
                  shreg     <= pix_data;
                  mosi      <= pix_data[PIX_W-1];
                  bitcnt    <= '0;
                  busy      <= 1'b1;
                  pix_ready <= 1'b0;
                  state     <= LOW;
`ifdef SPI_TX_CS_EN
                  // A sync on the accept edge makes this pixel index 0.
                  if (frame_sync || pix_idx == '0) cs_n <= 1'b0;
`endif
               end
            end

            LOW: begin
               if (frame_sync) sync_pend <= 1'b1;
               if (tick) begin
                  sck   <= 1'b1;
                  state <= HIGH;
               end
            end

            HIGH: begin
               if (frame_sync) sync_pend <= 1'b1;
               if (tick) begin
                  sck <= 1'b0;
                  if (bitcnt == LAST_BIT) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     pix_ready  <= 1'b1;
                     sync_pend  <= 1'b0;
                     frame_done <= (pix_idx == LAST_IDX);
                     pix_idx    <= frame_end ? '0 : pix_idx + 1'b1;
`ifdef SPI_TX_CS_EN
                     if (frame_end) cs_n <= 1'b1;
`endif
                  end else begin
                     // Next bit leaves on the sck falling edge: full half-period of setup.
                     bitcnt <= bitcnt + 1'b1;
                     shreg  <= shreg << 1;
                     mosi   <= shreg[PIX_W-2];
                     state  <= LOW;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sprite_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_sprite_tx
// Self-checking bench for spi_sprite_tx. dut_a uses the default 64x64 sprite,
// dut_b a 2x2 sprite for frame wrap; both share stimulus. A scoreboard queue
// holds accepted pixels; a monitor reassembles bits on sck rising edges of
// dut_a and compares them. Define SPI_TX_CS_EN to also check cs_n.
// -----------------------------------------------------------------------------
module tb_spi_sprite_tx;
   import spi_sprite_pkg::*;

   localparam int CLK_DIV   = 4;
   localparam int PIXEL_CYC = 2 * PIX_W * CLK_DIV;
   localparam int BUDGET    = 1000;

   logic   clk        = 1'b0;
   logic   reset_n    = 1'b1;
   logic   pix_valid  = 1'b0;
   logic   frame_sync = 1'b0;
   pixel_t pix_data   = '0;

   logic             pix_ready_a, sck_a, mosi_a, busy_a, frame_done_a;
   logic [IDX_W-1:0] pix_idx_a;
   logic             pix_ready_b, sck_b, mosi_b, busy_b, frame_done_b;
   logic [1:0]       pix_idx_b;
`ifdef SPI_TX_CS_EN
   logic             cs_n_a, cs_n_b;
`endif

   spi_sprite_tx #(.CLK_DIV(CLK_DIV)) dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready_a),
      .frame_sync (frame_sync),
      .sck        (sck_a),
      .mosi       (mosi_a),
      .busy       (busy_a),
      .pix_idx    (pix_idx_a),
      .frame_done (frame_done_a)
`ifdef SPI_TX_CS_EN
      ,
      .cs_n       (cs_n_a)
`endif
   );

   spi_sprite_tx #(.CLK_DIV(CLK_DIV), .SPRITE_W(2), .SPRITE_H(2), .IDX_W(2)) dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready_b),
      .frame_sync (frame_sync),
      .sck        (sck_b),
      .mosi       (mosi_b),
      .busy       (busy_b),
      .pix_idx    (pix_idx_b),
      .frame_done (frame_done_b)
`ifdef SPI_TX_CS_EN
      ,
      .cs_n       (cs_n_b)
`endif
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad   = 0;
   int     cyc   = 0;
   int     acc_cyc, prev_acc, done_cyc;
   int     mon_cnt  = 0;
   int     rise_cnt = 0;
   int     viol     = 0;
   int     fd_a_cnt = 0;
   int     fd_b_cnt = 0;
   logic   fd_b_rdy = 1'b0;
   logic   fd_b_csn = 1'b0;
   logic   sck_prev = 1'b0;
   logic   mosi_prev = 1'b0;
   pixel_t mon_word = '0;
   pixel_t exp_q[$];

   typedef struct {
      pixel_t data;
      int     exp_idx;
   } vec_t;
   vec_t tbl[3];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: no response within %0d cycles", name, BUDGET);
   endtask

   // Monitor: sample away from the active edge; detect sck rises by history.
   always @(negedge clk) begin
      pixel_t exp_pix;
      if (!reset_n) begin
         mon_cnt = 0;
      end else begin
         if (sck_a && !sck_prev) begin
            rise_cnt++;
            mon_word = {mon_word[PIX_W-2:0], mosi_a};
            mon_cnt++;
            if (mon_cnt == PIX_W) begin
               mon_cnt = 0;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_pixel: got %0h, expected none", mon_word);
               end else begin
                  exp_pix = exp_q.pop_front();
                  check("sb_pixel", mon_word, exp_pix);
               end
            end
         end
         if (sck_a && sck_prev && mosi_a != mosi_prev) viol++;
         if (frame_done_a) fd_a_cnt++;
         if (frame_done_b) begin
            fd_b_cnt++;
            fd_b_rdy = pix_ready_b;
`ifdef SPI_TX_CS_EN
            fd_b_csn = cs_n_b;
`endif
         end
      end
      sck_prev  = sck_a;
      mosi_prev = mosi_a;
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      pix_valid = 1'b0;
      frame_sync = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Called on a negedge; returns on the negedge after the accept edge.
   task automatic send(input pixel_t d, input bit keep, input bit sync);
      int n = 0;
      pix_data   = d;
      pix_valid  = 1'b1;
      frame_sync = sync;
      while (!pix_ready_a && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) timeout("accept");
      exp_q.push_back(d);
      acc_cyc = cyc + 1;
      @(negedge clk);
      frame_sync = 1'b0;
      if (!keep) begin
         pix_valid = 1'b0;
         pix_data  = ~d;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!pix_ready_a && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) timeout("completion");
      done_cyc = cyc;
   endtask

   task automatic wait_bits(input int bits);
      int n = 0;
      while (mon_cnt != bits && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) timeout("bit_wait");
   endtask

   initial begin
      int r0;
      tbl[0] = '{24'hFFFFFF, 2};
      tbl[1] = '{24'h000000, 3};
      tbl[2] = '{24'h123456, 4};

      // Reset state (async: visible before any clock edge)
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_pix_ready", pix_ready_a, 0);
      check("rst_sck", sck_a, 0);
      check("rst_mosi", mosi_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_pix_idx", pix_idx_a, 0);
      check("rst_frame_done", frame_done_a, 0);
`ifdef SPI_TX_CS_EN
      check("rst_cs_n", cs_n_a, 1);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", pix_ready_a, 1);

      // Test 1: single pixel, data changed after accept must not matter
      r0 = rise_cnt;
      send(24'hA5C3F0, 0, 0);
      check("busy_after_accept", busy_a, 1);
      wait_done();
      check("t1_latency", done_cyc - acc_cyc, PIXEL_CYC);
      check("t1_sck_rises", rise_cnt - r0, PIX_W);
      check("t1_pix_idx", pix_idx_a, 1);
      check("t1_mosi_holds_lsb", mosi_a, 0);

      // Test 2: back-to-back with pix_valid held high
      for (int i = 0; i < 3; i++) begin
         send(tbl[i].data, i < 2, 0);
         if (i > 0) check("t2_spacing", acc_cyc - prev_acc, PIXEL_CYC + 1);
         prev_acc = acc_cyc;
         wait_done();
         check("t2_latency", done_cyc - acc_cyc, PIXEL_CYC);
         check("t2_pix_idx", pix_idx_a, tbl[i].exp_idx);
      end
      check("t2_mosi_stable", viol, 0);

      // Test 3: 2x2 frame wrap on dut_b
      do_reset();
      fd_b_cnt = 0;
`ifdef SPI_TX_CS_EN
      check("t3_cs_n_idle", cs_n_b, 1);
`endif
      for (int i = 0; i < 4; i++) begin
         send(pixel_t'(24'h100000 * (i + 1) + 24'h00ABCD), 0, 0);
`ifdef SPI_TX_CS_EN
         check("t3_cs_n_active", cs_n_b, 0);
`endif
         wait_done();
         @(negedge clk);
         if (i < 3) check("t3_no_early_done", fd_b_cnt, 0);
      end
      check("t3_frame_done_once", fd_b_cnt, 1);
      check("t3_done_with_idle", fd_b_rdy, 1);
      check("t3_idx_wrap", pix_idx_b, 0);
`ifdef SPI_TX_CS_EN
      check("t3_cs_n_rise_with_done", fd_b_csn, 1);
`endif
      repeat (3) @(negedge clk);
      check("t3_pulse_width", fd_b_cnt, 1);

      // Test 4: frame_sync in IDLE, with accept, and while busy
      do_reset();
      fd_a_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         send(pixel_t'(24'h0F0F00 + i), 0, 0);
         wait_done();
      end
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      check("t4_sync_idle", pix_idx_a, 0);
      send(24'hC0FFEE, 0, 1);
      wait_done();
      check("t4_sync_accept", pix_idx_a, 1);
      for (int i = 0; i < 4; i++) begin
         send(pixel_t'(24'h314159 + i), 0, 0);
         wait_done();
      end
      check("t4_idx5", pix_idx_a, 5);
      send(24'h9ABCDE, 0, 0);
      wait_bits(10);
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      check("t4_busy_during_sync", busy_a, 1);
      check("t4_idx_deferred", pix_idx_a, 5);
      wait_done();
      @(negedge clk);
      check("t4_idx_after_sync", pix_idx_a, 0);
      check("t4_no_frame_done", fd_a_cnt, 0);

      // Test 5: reset mid-pixel
      do_reset();
      send(24'hFE00FF, 0, 0);
      wait_bits(7);
      reset_n = 1'b0;
      #1;
      check("t5_sck_abort", sck_a, 0);
      check("t5_mosi_abort", mosi_a, 0);
      check("t5_busy_abort", busy_a, 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("t5_ready", pix_ready_a, 1);
      check("t5_idx", pix_idx_a, 0);
      send(24'h5A3C96, 0, 0);
      wait_done();
      @(negedge clk);
      check("t5_idx_after", pix_idx_a, 1);

      check("mosi_stable_total", viol, 0);
      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
